// File: rtl/ts_reader_pkg.sv
// Shared constants for the build-timestamp JTAG reader: instruction codes,
// data-register lengths and the bit layout of the 48-bit timestamp frame.
package ts_reader_pkg;

    localparam logic [1:0] IR_BYPASS  = 2'd0;
    localparam logic [1:0] IR_READ_TS = 2'd1;
    localparam logic [1:0] IR_READ_ID = 2'd2;
    localparam logic [1:0] IR_CLR_ERR = 2'd3;

    localparam int TS_LEN    = 48;
    localparam int ID_LEN    = 16;
    localparam int BYP_LEN   = 1;
    localparam int PAYLOAD_W = 38;

    // Frame layout, LSB first on the wire: 0, parity, minute .. revision, sync byte
    localparam int PAR_BIT     = 1;
    localparam int PAYLOAD_LSB = 2;
    localparam int MIN_LSB     = 2;
    localparam int HOUR_LSB    = 8;
    localparam int DAY_LSB     = 13;
    localparam int MONTH_LSB   = 18;
    localparam int YEAR_LSB    = 22;
    localparam int SUBREV_LSB  = 29;
    localparam int REV_LSB     = 33;
    localparam int SYNC_LSB    = 40;

    function automatic logic [5:0] dr_len(input logic [1:0] ir);
        case (ir)
            IR_READ_TS: dr_len = 6'(TS_LEN);
            IR_READ_ID: dr_len = 6'(ID_LEN);
            default:    dr_len = 6'(BYP_LEN);
        endcase
    endfunction

endpackage

// File: rtl/ts_frame_pack.sv
// Combinational packing of the timestamp fields into the framed TS data register,
// with even parity over the 38 payload bits.
module ts_frame_pack
    import ts_reader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic [6:0]        revision,
    input  logic [3:0]        subrevision,
    input  logic [6:0]        year,
    input  logic [3:0]        month,
    input  logic [4:0]        day,
    input  logic [4:0]        hour,
    input  logic [5:0]        minute,
    output logic [TS_LEN-1:0] frame
);

    always_comb begin
        frame = '0;
        frame[SYNC_LSB +: 8]   = SYNC_BYTE;
        frame[REV_LSB +: 7]    = revision;
        frame[SUBREV_LSB +: 4] = subrevision;
        frame[YEAR_LSB +: 7]   = year;
        frame[MONTH_LSB +: 4]  = month;
        frame[DAY_LSB +: 5]    = day;
        frame[HOUR_LSB +: 5]   = hour;
        frame[MIN_LSB +: 6]    = minute;
        frame[PAR_BIT]         = ^frame[PAYLOAD_LSB +: PAYLOAD_W];
    end

endmodule

// File: rtl/timestamp_jtag_reader.sv
// Virtual-JTAG data-register side for reading the FPGA build timestamp,
// with BYPASS and ID registers and frame/shift-count status flags.
module timestamp_jtag_reader
    import ts_reader_pkg::*;
#(
    parameter logic [15:0] ID_CODE   = 16'h7E57,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] ir_in,
    input  logic       v_cdr,
    input  logic       v_sdr,
    input  logic       v_udr,
    input  logic       tdi,
    output logic       tdo,
    input  logic [6:0] revision,
    input  logic [3:0] subrevision,
    input  logic [6:0] year,
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [4:0] hour,
    input  logic [5:0] minute,
    output logic       frame_read,
    output logic       shift_err,
    output logic [5:0] bit_count
);

    logic [TS_LEN-1:0] frame;
    logic [TS_LEN-1:0] ts_dr;
    logic [ID_LEN-1:0] id_dr;
    logic              byp_dr;
    logic [1:0]        ir_lat;

    ts_frame_pack #(.SYNC_BYTE(SYNC_BYTE)) u_pack (
        .revision    (revision),
        .subrevision (subrevision),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .frame       (frame)
    );

    // Strobes are single-clk qualifiers with fixed priority v_cdr > v_sdr > v_udr;
    // a lower strobe asserted together with a higher one is dropped for that clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_dr      <= '0;
            id_dr      <= '0;
            byp_dr     <= 1'b0;
            ir_lat     <= IR_BYPASS;
            bit_count  <= '0;
            frame_read <= 1'b0;
            shift_err  <= 1'b0;
            tdo        <= 1'b0;
        end else begin
            frame_read <= 1'b0;
            if (v_cdr) begin
                ir_lat    <= ir_in;
                bit_count <= '0;
                case (ir_in)
                    IR_READ_TS: begin
                        ts_dr <= frame;
                        tdo   <= frame[0];
                    end
                    IR_READ_ID: begin
                        id_dr <= ID_CODE;
                        tdo   <= ID_CODE[0];
                    end
                    default: begin
                        byp_dr <= 1'b0;
                        tdo    <= 1'b0;
                    end
                endcase
                if (ir_in == IR_CLR_ERR) shift_err <= 1'b0;
            end else if (v_sdr) begin
                if (bit_count != 6'd63) bit_count <= bit_count + 6'd1;
                // Register selection follows the instruction latched at capture
                case (ir_lat)
                    IR_READ_TS: begin
                        ts_dr <= {tdi, ts_dr[TS_LEN-1:1]};
                        tdo   <= ts_dr[1];
                    end
                    IR_READ_ID: begin
                        id_dr <= {tdi, id_dr[ID_LEN-1:1]};
                        tdo   <= id_dr[1];
                    end
                    default: begin
                        byp_dr <= tdi;
                        tdo    <= tdi;
                    end
                endcase
            end else if (v_udr) begin
                if (bit_count == dr_len(ir_lat)) frame_read <= (ir_lat == IR_READ_TS);
                else                             shift_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timestamp_jtag_reader.sv
// Directed bench for timestamp_jtag_reader: timestamp frame, ID, bypass,
// shift-count errors, over-shift recirculation, strobe priority and async reset.
module tb_timestamp_jtag_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] ir_in;
    logic       v_cdr, v_sdr, v_udr, tdi;
    logic       tdo;
    logic [6:0] revision;
    logic [3:0] subrevision;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic [4:0] hour;
    logic [5:0] minute;
    logic       frame_read, shift_err;
    logic [5:0] bit_count;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_q[$];
    logic [47:0] exp_ts;
    logic [47:0] got48, got48b, pattern;
    logic [15:0] got16;
    logic        b;

    timestamp_jtag_reader dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ir_in       (ir_in),
        .v_cdr       (v_cdr),
        .v_sdr       (v_sdr),
        .v_udr       (v_udr),
        .tdi         (tdi),
        .tdo         (tdo),
        .revision    (revision),
        .subrevision (subrevision),
        .year        (year),
        .month       (month),
        .day         (day),
        .hour        (hour),
        .minute      (minute),
        .frame_read  (frame_read),
        .shift_err   (shift_err),
        .bit_count   (bit_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [1:0] ir);
        ir_in = ir;
        v_cdr = 1'b1;
        tick();
        v_cdr = 1'b0;
    endtask

    task automatic shift(input logic din, output logic dout);
        dout  = tdo;
        tdi   = din;
        v_sdr = 1'b1;
        tick();
        v_sdr = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic update();
        v_udr = 1'b1;
        tick();
        v_udr = 1'b0;
    endtask

    task automatic shift48(input logic [47:0] din, output logic [47:0] dout);
        logic o;
        for (int i = 0; i < 48; i++) begin
            shift(din[i], o);
            dout[i] = o;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        ir_in = 2'd0; v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0; tdi = 1'b0;
        revision = 7'h46; subrevision = 4'h2; year = 7'h17; month = 4'h1;
        day = 5'h11; hour = 5'h12; minute = 6'h0C;
        // Payload popcount 3+1+4+1+2+2+2 = 15, so even parity bit is 1
        exp_ts = {8'hA5, 7'h46, 4'h2, 7'h17, 4'h1, 5'h11, 5'h12, 6'h0C, 1'b1, 1'b0};
        repeat (3) tick();
        check("reset_tdo", tdo, 0);
        check("reset_bit_count", bit_count, 0);
        check("reset_frame_read", frame_read, 0);
        check("reset_shift_err", shift_err, 0);
        reset_n = 1'b1;
        tick();

        // 1: timestamp frame
        capture(2'd1);
        check("t1_count_after_cdr", bit_count, 0);
        exp_q.push_back(exp_ts);
        shift48(48'h0, got48);
        check("t1_frame", got48, exp_q.pop_front());
        check("t1_sync", got48[47:40], 8'hA5);
        check("t1_parity", got48[1], 1);
        check("t1_bit0", got48[0], 0);
        check("t1_count_48", bit_count, 48);
        update();
        check("t1_frame_read", frame_read, 1);
        check("t1_no_err", shift_err, 0);
        tick();
        check("t1_frame_read_drop", frame_read, 0);

        // 2: ID register
        capture(2'd2);
        for (int i = 0; i < 16; i++) begin
            shift(1'b0, b);
            got16[i] = b;
        end
        check("t2_id", got16, 16'h7E57);
        update();
        check("t2_frame_read", frame_read, 0);
        check("t2_no_err", shift_err, 0);

        // 3: short shift sets sticky error; IR=3 capture clears it
        capture(2'd1);
        for (int i = 0; i < 47; i++) shift(1'b0, b);
        update();
        check("t3_err_set", shift_err, 1);
        check("t3_no_frame_read", frame_read, 0);
        repeat (2) tick();
        check("t3_err_sticky", shift_err, 1);
        capture(2'd0);
        check("t3_bypass_no_clear", shift_err, 1);
        capture(2'd3);
        check("t3_err_cleared", shift_err, 0);
        shift(1'b1, b);
        check("t3_bypass_out", tdo, 1);
        update();
        check("t3_bypass_len_ok", shift_err, 0);

        // 4: over-shift recirculates tdi, count saturates
        pattern = 48'hC3A5_9F01_6E2B;
        capture(2'd1);
        shift48(pattern, got48);
        check("t4_first_frame", got48, exp_ts);
        shift48(48'h0, got48b);
        check("t4_recirc", got48b, pattern);
        check("t4_count_sat", bit_count, 63);
        update();
        check("t4_err", shift_err, 1);
        check("t4_no_frame_read", frame_read, 0);
        capture(2'd3);

        // 5: capture wins over shift; ir_in change mid-shift ignored
        ir_in = 2'd1;
        v_cdr = 1'b1;
        v_sdr = 1'b1;
        tdi   = 1'b1;
        tick();
        v_cdr = 1'b0;
        v_sdr = 1'b0;
        tdi   = 1'b0;
        check("t5_count_zero", bit_count, 0);
        check("t5_first_bit", tdo, 0);
        for (int i = 0; i < 20; i++) begin
            shift(1'b0, b);
            got48[i] = b;
        end
        ir_in = 2'd2;
        for (int i = 20; i < 48; i++) begin
            shift(1'b0, b);
            got48[i] = b;
        end
        check("t5_frame_intact", got48, exp_ts);
        update();
        check("t5_frame_read", frame_read, 1);

        // 6: asynchronous reset mid-shift
        capture(2'd2);
        for (int i = 0; i < 3; i++) shift(1'b0, b);
        update();
        check("t6_err_pre", shift_err, 1);
        capture(2'd1);
        for (int i = 0; i < 20; i++) shift(1'b0, b);
        check("t6_count_20", bit_count, 20);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_tdo", tdo, 0);
        check("t6_async_count", bit_count, 0);
        check("t6_async_err", shift_err, 0);
        check("t6_async_frame_read", frame_read, 0);
        tick();
        reset_n = 1'b1;
        tick();
        capture(2'd1);
        shift48(48'h0, got48);
        check("t6_recapture", got48, exp_ts);
        update();
        check("t6_frame_read", frame_read, 1);
        check("t6_no_err", shift_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
